// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_pkg : opcode constants and EX control-bundle layout          |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package pipeline_pkg;

  localparam int OPC_W = 7;
  localparam int REG_W = 5;

  localparam logic [OPC_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_NOP_I = 7'b0010011;

  typedef struct packed {
    logic             valid;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
  } ex_ctrl_t;

  // Bubble encodes addi x0,x0,0 with every side-effect bit cleared.
  localparam ex_ctrl_t EX_CTRL_NOP = '{
    valid: 1'b0, opcode: OP_NOP_I, rs1: '0, rs2: '0, rd: '0,
    regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0
  };

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_use_detect : flags an ID instruction reading the rd of a load    |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic             id_rs1_used_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_rs2_used_i,
  output logic             load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_used_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_rs2_used_i && (id_rs2_i == ex_rd_i);

  // x0 never holds a produced value, so a load to x0 cannot create a hazard.
  assign load_use_o = ex_valid_i && ex_memread_i && (ex_rd_i != '0) &&
                      id_valid_i && (rs1_hit || rs2_hit);

endmodule
`default_nettype wire

// File: rtl/idex_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | idex_stage_reg : ID->EX register with load-use bubble and flush/hold  |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module idex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  input  logic [OPC_W-1:0] i_id_opcode,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [REG_W-1:0] i_id_rd,
  input  logic             i_id_regwrite,
  input  logic             i_id_memread,
  input  logic             i_id_memwrite,
  input  logic [XLEN-1:0]  i_id_rs1_data,
  input  logic [XLEN-1:0]  i_id_rs2_data,
  input  logic [XLEN-1:0]  i_id_imm,
  input  logic [XLEN-1:0]  i_id_pc,
  input  logic             i_flush,
  input  logic             i_hold,
  output logic             o_ex_valid,
  output logic [OPC_W-1:0] o_ex_opcode,
  output logic [REG_W-1:0] o_ex_rs1,
  output logic [REG_W-1:0] o_ex_rs2,
  output logic [REG_W-1:0] o_ex_rd,
  output logic             o_ex_regwrite,
  output logic             o_ex_memread,
  output logic             o_ex_memwrite,
  output logic [XLEN-1:0]  o_ex_rs1_data,
  output logic [XLEN-1:0]  o_ex_rs2_data,
  output logic [XLEN-1:0]  o_ex_imm,
  output logic [XLEN-1:0]  o_ex_pc,
  output logic             o_stall_front,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  ex_ctrl_t           ctrl_q,     ctrl_d;
  logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]    imm_q,      imm_d;
  logic [XLEN-1:0]    pc_q,       pc_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               load_use;

  load_use_detect u_load_use_detect (
    .ex_valid_i    (ctrl_q.valid),
    .ex_memread_i  (ctrl_q.memread),
    .ex_rd_i       (ctrl_q.rd),
    .id_valid_i    (i_id_valid),
    .id_rs1_i      (i_id_rs1),
    .id_rs1_used_i (i_id_rs1_used),
    .id_rs2_i      (i_id_rs2),
    .id_rs2_used_i (i_id_rs2_used),
    .load_use_o    (load_use)
  );

  assign o_stall_front = (load_use && !i_flush) || i_hold;

  always_comb begin
    ctrl_d     = ctrl_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    if (i_hold) begin
      // whole pipe frozen; hazard is re-evaluated once the hold lifts
    end else if (i_flush || load_use) begin
      ctrl_d     = EX_CTRL_NOP;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      pc_d       = '0;
      if (!i_flush && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end else begin
      ctrl_d.valid    = i_id_valid;
      ctrl_d.opcode   = i_id_opcode;
      ctrl_d.rs1      = i_id_rs1;
      ctrl_d.rs2      = i_id_rs2;
      ctrl_d.rd       = i_id_valid ? i_id_rd : '0;
      ctrl_d.regwrite = i_id_valid && i_id_regwrite;
      ctrl_d.memread  = i_id_valid && i_id_memread;
      ctrl_d.memwrite = i_id_valid && i_id_memwrite;
      rs1_data_d      = i_id_rs1_data;
      rs2_data_d      = i_id_rs2_data;
      imm_d           = i_id_imm;
      pc_d            = i_id_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      cnt_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_ex_valid    = ctrl_q.valid;
  assign o_ex_opcode   = ctrl_q.opcode;
  assign o_ex_rs1      = ctrl_q.rs1;
  assign o_ex_rs2      = ctrl_q.rs2;
  assign o_ex_rd       = ctrl_q.rd;
  assign o_ex_regwrite = ctrl_q.regwrite;
  assign o_ex_memread  = ctrl_q.memread;
  assign o_ex_memwrite = ctrl_q.memwrite;
  assign o_ex_rs1_data = rs1_data_q;
  assign o_ex_rs2_data = rs2_data_q;
  assign o_ex_imm      = imm_q;
  assign o_ex_pc       = pc_q;
  assign o_bubble_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_idex_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_idex_stage_reg : directed checks of load-use, flush, hold, reset   |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_idex_stage_reg;
  import pipeline_pkg::*;

  localparam int XLEN = 32;
  localparam int CNT_W = 32;
  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 0, rs1_used = 0, rs2_used = 0, regwrite = 0, memread = 0, memwrite = 0;
  logic [6:0] opcode = '0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic [XLEN-1:0] rs1_data = '0, rs2_data = '0, imm = '0, pc = '0;
  logic flush = 0, hold = 0;

  logic ex_valid, ex_regwrite, ex_memread, ex_memwrite, stall;
  logic [6:0] ex_opcode;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [CNT_W-1:0] cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  idex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_id_valid(id_valid), .i_id_opcode(opcode), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used), .i_id_rd(rd),
    .i_id_regwrite(regwrite), .i_id_memread(memread), .i_id_memwrite(memwrite),
    .i_id_rs1_data(rs1_data), .i_id_rs2_data(rs2_data), .i_id_imm(imm), .i_id_pc(pc),
    .i_flush(flush), .i_hold(hold),
    .o_ex_valid(ex_valid), .o_ex_opcode(ex_opcode), .o_ex_rs1(ex_rs1), .o_ex_rs2(ex_rs2),
    .o_ex_rd(ex_rd), .o_ex_regwrite(ex_regwrite), .o_ex_memread(ex_memread),
    .o_ex_memwrite(ex_memwrite), .o_ex_rs1_data(ex_rs1_data), .o_ex_rs2_data(ex_rs2_data),
    .o_ex_imm(ex_imm), .o_ex_pc(ex_pc), .o_stall_front(stall), .o_bubble_cnt(cnt)
  );

  // Presents one decoded instruction in ID (called at a negedge).
  task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] s1, input logic u1,
                        input logic [4:0] s2, input logic u2, input logic [4:0] d,
                        input logic rw, input logic mr, input logic mw, input logic [XLEN-1:0] p);
    id_valid = v; opcode = op; rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2;
    rd = d; regwrite = rw; memread = mr; memwrite = mw; pc = p;
    rs1_data = 32'h1000_0000 | p; rs2_data = 32'h2000_0000 | p; imm = 32'h0000_0004;
  endtask

  task automatic set_idle();
    set_id(1'b0, 7'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic edge_sample();
    @(posedge clk); #1;
  endtask

  task automatic put_load(input logic [4:0] d, input logic [4:0] base, input logic [XLEN-1:0] p);
    @(negedge clk);
    set_id(1'b1, OP_LOAD, base, 1'b1, 5'd0, 1'b0, d, 1'b1, 1'b1, 1'b0, p);
    edge_sample();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ex_valid, ex_opcode, ex_rd, ex_regwrite, ex_memread, ex_memwrite} !== '0 || cnt !== '0) begin
      errors++; $display("FAIL reset_state: valid=%b opcode=%h rd=%0d cnt=%0d required all 0", ex_valid, ex_opcode, ex_rd, cnt);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_load_use();
    put_load(5'd5, 5'd1, 32'h100);
    checks++;
    if (ex_memread !== 1'b1 || ex_rd !== 5'd5 || ex_pc !== 32'h100 || ex_rs1_data !== 32'h1000_0100) begin
      errors++; $display("FAIL lu_load_in_ex: memread=%b rd=%0d pc=%h d1=%h required 1 5 100 10000100", ex_memread, ex_rd, ex_pc, ex_rs1_data);
    end
    @(negedge clk);
    set_id(1'b1, OP_ADD, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h104);
    #1; checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: stall=%b required 1", stall); end
    edge_sample(); checks++;
    if (ex_valid !== 1'b0 || ex_opcode !== OP_NOP_I || ex_rd !== 5'd0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 || cnt !== 32'd1) begin
      errors++; $display("FAIL lu_bubble: valid=%b op=%h rd=%0d rw=%b mr=%b cnt=%0d required 0 13 0 0 0 1", ex_valid, ex_opcode, ex_rd, ex_regwrite, ex_memread, cnt);
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once: stall=%b required 0", stall); end
    edge_sample(); checks++;
    if (ex_valid !== 1'b1 || ex_opcode !== OP_ADD || ex_rd !== 5'd6 || ex_pc !== 32'h104 || cnt !== 32'd1) begin
      errors++; $display("FAIL lu_add_in_ex: valid=%b op=%h rd=%0d pc=%h cnt=%0d required 1 33 6 104 1", ex_valid, ex_opcode, ex_rd, ex_pc, cnt);
    end
  endtask

  task automatic test_x0_load();
    put_load(5'd0, 5'd1, 32'h200);
    @(negedge clk);
    set_id(1'b1, OP_ADD, 5'd0, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h204);
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL x0_no_stall: stall=%b required 0", stall); end
    edge_sample(); checks++;
    if (ex_valid !== 1'b1 || ex_opcode !== OP_ADD || ex_pc !== 32'h204 || cnt !== 32'd1) begin
      errors++; $display("FAIL x0_add_in_ex: valid=%b op=%h pc=%h cnt=%0d required 1 33 204 1", ex_valid, ex_opcode, ex_pc, cnt);
    end
  endtask

  task automatic test_store_and_imm();
    put_load(5'd5, 5'd1, 32'h300);
    @(negedge clk);
    set_id(1'b1, OP_STORE, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 32'h304);
    #1; checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL store_rs2_stall: stall=%b required 1", stall); end
    edge_sample(); checks++;
    if (ex_valid !== 1'b0 || ex_memwrite !== 1'b0 || cnt !== 32'd2) begin
      errors++; $display("FAIL store_bubble: valid=%b mw=%b cnt=%0d required 0 0 2", ex_valid, ex_memwrite, cnt);
    end
    edge_sample(); checks++;
    if (ex_memwrite !== 1'b1 || ex_opcode !== OP_STORE || ex_rs2 !== 5'd5) begin
      errors++; $display("FAIL store_in_ex: mw=%b op=%h rs2=%0d required 1 23 5", ex_memwrite, ex_opcode, ex_rs2);
    end
    put_load(5'd5, 5'd1, 32'h310);
    @(negedge clk);
    set_id(1'b1, OP_NOP_I, 5'd1, 1'b1, 5'd5, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h314);
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL addi_no_stall: stall=%b required 0", stall); end
    edge_sample(); checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || cnt !== 32'd2) begin
      errors++; $display("FAIL addi_in_ex: valid=%b rd=%0d cnt=%0d required 1 7 2", ex_valid, ex_rd, cnt);
    end
  endtask

  task automatic test_flush();
    put_load(5'd5, 5'd1, 32'h400);
    @(negedge clk);
    set_id(1'b1, OP_ADD, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h404);
    flush = 1'b1;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_no_stall: stall=%b required 0", stall); end
    edge_sample(); checks++;
    if (ex_valid !== 1'b0 || ex_opcode !== OP_NOP_I || ex_regwrite !== 1'b0 || ex_pc !== 32'd0 || cnt !== 32'd2) begin
      errors++; $display("FAIL flush_bubble: valid=%b op=%h rw=%b pc=%h cnt=%0d required 0 13 0 0 2", ex_valid, ex_opcode, ex_regwrite, ex_pc, cnt);
    end
    @(negedge clk); flush = 1'b0; set_idle();
  endtask

  task automatic test_hold();
    put_load(5'd5, 5'd1, 32'h500);
    @(negedge clk);
    set_id(1'b1, OP_ADD, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h504);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d]: stall=%b required 1", i, stall); end
      edge_sample(); checks++;
      if (ex_memread !== 1'b1 || ex_rd !== 5'd5 || ex_pc !== 32'h500 || cnt !== 32'd2) begin
        errors++; $display("FAIL hold_frozen[%0d]: mr=%b rd=%0d pc=%h cnt=%0d required 1 5 500 2", i, ex_memread, ex_rd, ex_pc, cnt);
      end
      @(negedge clk);
    end
    hold = 1'b0;
    #1; checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL hold_release_stall: stall=%b required 1", stall); end
    edge_sample(); checks++;
    if (ex_valid !== 1'b0 || cnt !== 32'd3 || stall !== 1'b0) begin
      errors++; $display("FAIL hold_release_bubble: valid=%b cnt=%0d stall=%b required 0 3 0", ex_valid, cnt, stall);
    end
    edge_sample();
  endtask

  task automatic test_back_to_back();
    put_load(5'd5, 5'd1, 32'h600);
    @(negedge clk);
    set_id(1'b1, OP_LOAD, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 32'h604);
    edge_sample(); checks++;
    if (ex_valid !== 1'b0 || cnt !== 32'd4 || stall !== 1'b0) begin
      errors++; $display("FAIL b2b_bubble1: valid=%b cnt=%0d stall=%b required 0 4 0", ex_valid, cnt, stall);
    end
    edge_sample(); checks++;
    if (ex_memread !== 1'b1 || ex_rd !== 5'd6) begin
      errors++; $display("FAIL b2b_load2_in_ex: mr=%b rd=%0d required 1 6", ex_memread, ex_rd);
    end
    @(negedge clk);
    set_id(1'b1, OP_LOAD, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 32'h608);
    #1; checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall2: stall=%b required 1", stall); end
    edge_sample(); checks++;
    if (ex_valid !== 1'b0 || cnt !== 32'd5) begin
      errors++; $display("FAIL b2b_bubble2: valid=%b cnt=%0d required 0 5", ex_valid, cnt);
    end
    edge_sample(); checks++;
    if (ex_rd !== 5'd7 || ex_memread !== 1'b1 || cnt !== 32'd5) begin
      errors++; $display("FAIL b2b_load3_in_ex: rd=%0d mr=%b cnt=%0d required 7 1 5", ex_rd, ex_memread, cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_id(1'b1, OP_ADD, 5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 32'h700);
    #1; checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre_stall: stall=%b required 1", stall); end
    #1 rst = 1'b1;
    #1; checks++;
    if ({ex_valid, ex_opcode, ex_rd, ex_regwrite, ex_memread, ex_memwrite} !== '0 || ex_pc !== '0 || cnt !== '0 || stall !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear: valid=%b op=%h rd=%0d mr=%b cnt=%0d stall=%b required all 0", ex_valid, ex_opcode, ex_rd, ex_memread, cnt, stall);
    end
    @(negedge clk); rst = 1'b0; set_idle();
    edge_sample(); checks++;
    if (ex_valid !== 1'b0 || cnt !== 32'd0) begin
      errors++; $display("FAIL rstmid_after: valid=%b cnt=%0d required 0 0", ex_valid, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_load();
    test_store_and_imm();
    test_flush();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
